// File: rtl/bldc_pkg.sv
// Shared types and helpers for the BLDC six-step commutator.
// Phase roles, FSM states, invalid Hall codes and the commutation table.
package bldc_pkg;

    typedef enum logic [1:0] {
        ROLE_OFF = 2'd0,
        ROLE_HI  = 2'd1,
        ROLE_LO  = 2'd2
    } role_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_BRAKE = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    typedef struct packed {
        role_t a;
        role_t b;
        role_t c;
    } roles_t;

    localparam logic [2:0] HALL_INV0 = 3'b000;
    localparam logic [2:0] HALL_INV7 = 3'b111;

    function automatic logic hall_valid(input logic [2:0] hall);
        return (hall != HALL_INV0) && (hall != HALL_INV7);
    endfunction

    // Forward table; reverse direction swaps the high and low phase.
    function automatic roles_t comm_lookup(input logic [2:0] hall, input logic dir);
        roles_t r;
        role_t  hi_r;
        role_t  lo_r;
        hi_r = dir ? ROLE_LO : ROLE_HI;
        lo_r = dir ? ROLE_HI : ROLE_LO;
        r.a  = ROLE_OFF;
        r.b  = ROLE_OFF;
        r.c  = ROLE_OFF;
        case (hall)
            3'b101: begin r.a = hi_r; r.b = lo_r; end
            3'b100: begin r.a = hi_r; r.c = lo_r; end
            3'b110: begin r.b = hi_r; r.c = lo_r; end
            3'b010: begin r.b = hi_r; r.a = lo_r; end
            3'b011: begin r.c = hi_r; r.a = lo_r; end
            3'b001: begin r.c = hi_r; r.b = lo_r; end
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bldc_pwm_gen.sv
// PWM generator: prescaled tick, counter 0..2^PWM_W-2, duty reloaded only at wrap
// so a DUTY change never produces a runt pulse inside a period.
module bldc_pwm_gen #(
    parameter int PWM_W     = 4,
    parameter int PRESC_DIV = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PWM_W-1:0] duty,
    output logic             pwm_on
);
    localparam int PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
    localparam logic [PW-1:0]    PRESC_TOP = PW'(PRESC_DIV - 1);
    localparam logic [PWM_W-1:0] CNT_TOP   = {{(PWM_W-1){1'b1}}, 1'b0};

    logic [PW-1:0]    presc;
    logic [PWM_W-1:0] cnt;
    logic [PWM_W-1:0] duty_q;
    logic             tick;

    assign tick   = (presc == PRESC_TOP);
    assign pwm_on = (cnt < duty_q);

    // Prescaler, period counter and wrap-aligned duty reload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc  <= '0;
            cnt    <= '0;
            duty_q <= '0;
        end else begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick) begin
                if (cnt == CNT_TOP) begin
                    cnt    <= '0;
                    duty_q <= duty;
                end else begin
                    cnt <= cnt + PWM_W'(1);
                end
            end
        end
    end
endmodule

// File: rtl/bldc_commutator_pwm.sv
// Six-step BLDC commutation controller: Hall sync/filter, IDLE/RUN/BRAKE/FAULT FSM,
// commutation-period measurement and gate drive with PWM on the high side.
// Optional macro DEADTIME_EN inserts DEAD_CYC off cycles on every phase role change.
module bldc_commutator_pwm
    import bldc_pkg::*;
#(
    parameter int PWM_W       = 4,
    parameter int PRESC_DIV   = 1,
    parameter int HALL_STABLE = 4,
    parameter int DEAD_CYC    = 2,
    parameter int CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [2:0]       HALL,
    input  logic [PWM_W-1:0] DUTY,
    input  logic             EN,
    input  logic             DIR,
    input  logic             BRAKE,
    input  logic             CLR_FAULT,
    output logic             A,
    output logic             B,
    output logic             C,
    output logic             AA,
    output logic             BB,
    output logic             CC,
    output logic             FAULT,
    output logic             STALL,
    output logic [CNT_W-1:0] COMM_PERIOD
);
    localparam int SW = $clog2(HALL_STABLE + 1);

`ifdef DEADTIME_EN
    localparam int DT_LEN = DEAD_CYC;
`else
    // DEAD_CYC is accepted but has no effect when dead time is not built in.
    localparam int DT_LEN = 0 * DEAD_CYC;
`endif

    logic [2:0]       s1, s2, cand, hall_f;
    logic [SW-1:0]    scnt;
    logic             acc;
    logic [CNT_W-1:0] pcnt;
    logic             dir_q;
    state_t           state, nxt;
    roles_t           r;
    role_t [2:0]      des;
    role_t [2:0]      app;
    logic             pwm_on;

    // A candidate that has held for HALL_STABLE samples is accepted one cycle later.
    assign acc = (scnt == SW'(HALL_STABLE)) && (cand != hall_f);

    // Hall synchroniser, stability filter and accepted code.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1     <= '0;
            s2     <= '0;
            cand   <= '0;
            scnt   <= '0;
            hall_f <= '0;
        end else begin
            s1 <= HALL;
            s2 <= s1;
            if (s2 != cand) begin
                cand <= s2;
                scnt <= SW'(1);
            end else if (scnt != SW'(HALL_STABLE)) begin
                scnt <= scnt + SW'(1);
            end
            if (acc) hall_f <= cand;
        end
    end

    // Period counter starts at 1 so the first report counts cycles since reset
    // the same way later reports count cycles between changes.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pcnt        <= CNT_W'(1);
            COMM_PERIOD <= '0;
            dir_q       <= 1'b0;
        end else begin
            dir_q <= DIR;
            if (acc && hall_valid(cand)) begin
                COMM_PERIOD <= pcnt;
                pcnt        <= CNT_W'(1);
            end else if (pcnt != '1) begin
                pcnt <= pcnt + CNT_W'(1);
            end
        end
    end

    assign STALL = &pcnt;

    // FSM state register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= ST_IDLE;
        else        state <= nxt;
    end

    // Next state: fault beats brake beats enable.
    always_comb begin
        nxt = state;
        if (acc && !hall_valid(cand)) begin
            nxt = ST_FAULT;
        end else begin
            case (state)
                ST_FAULT: if (CLR_FAULT && hall_valid(hall_f)) nxt = ST_IDLE;
                ST_IDLE:  if (BRAKE) nxt = ST_BRAKE; else if (EN)  nxt = ST_RUN;
                ST_RUN:   if (BRAKE) nxt = ST_BRAKE; else if (!EN) nxt = ST_IDLE;
                ST_BRAKE: if (!BRAKE) nxt = ST_IDLE;
                default:  nxt = ST_IDLE;
            endcase
        end
    end

    // Desired phase roles from state and accepted Hall code.
    always_comb begin
        r = comm_lookup(hall_f, dir_q);
        case (state)
            ST_RUN:   des = {r.c, r.b, r.a};
            ST_BRAKE: des = {ROLE_LO, ROLE_LO, ROLE_LO};
            default:  des = {ROLE_OFF, ROLE_OFF, ROLE_OFF};
        endcase
    end

    assign FAULT = (state == ST_FAULT);

    bldc_pwm_gen #(.PWM_W(PWM_W), .PRESC_DIV(PRESC_DIV)) u_pwm (
        .clk    (CLK),
        .rst_n  (RST_N),
        .duty   (DUTY),
        .pwm_on (pwm_on)
    );

    if (DT_LEN > 0) begin : g_dt
        localparam int DW = $clog2(DT_LEN + 1);
        for (genvar p = 0; p < 3; p++) begin : g_ph
            role_t         tgt;
            logic [DW-1:0] dcnt;
            // Track each phase's target role; a change blanks the phase for DT_LEN
            // cycles (the cycle the change is seen plus DT_LEN-1 counted cycles).
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    tgt  <= ROLE_OFF;
                    dcnt <= '0;
                end else if (des[p] != tgt) begin
                    tgt  <= des[p];
                    dcnt <= DW'(DT_LEN - 1);
                end else if (dcnt != '0) begin
                    dcnt <= dcnt - DW'(1);
                end
            end
            assign app[p] = ((des[p] == tgt) && (dcnt == '0)) ? tgt : ROLE_OFF;
        end
    end else begin : g_nodt
        assign app = des;
    end

    // One role per phase, so high and low gates of a phase can never overlap.
    assign A  = (app[0] == ROLE_HI) && pwm_on;
    assign B  = (app[1] == ROLE_HI) && pwm_on;
    assign C  = (app[2] == ROLE_HI) && pwm_on;
    assign AA = (app[0] == ROLE_LO);
    assign BB = (app[1] == ROLE_LO);
    assign CC = (app[2] == ROLE_LO);
endmodule

// File: tb/tb_bldc_commutator_pwm.sv
// Directed bench for bldc_commutator_pwm: commutation table vectors plus
// hand-written reset, glitch, fault, brake, duty-reload and dead-time sequences.
module tb_bldc_commutator_pwm;
`ifdef DEADTIME_EN
    localparam int DT = 2;
`else
    localparam int DT = 0;
`endif

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [2:0]  HALL;
    logic [3:0]  DUTY;
    logic        EN, DIR, BRAKE, CLR_FAULT;
    logic        A, B, C, AA, BB, CC, FAULT, STALL;
    logic [15:0] COMM_PERIOD;

    int total = 0;
    int bad   = 0;
    int ovl   = 0;

    typedef struct {
        logic [2:0]  hall;
        logic        dir;
        logic [5:0]  gates;   // {A,B,C,AA,BB,CC}
        logic [15:0] per;     // 0 = period not checked for this entry
    } vec_t;

    vec_t tab [12];

    bldc_commutator_pwm dut (
        .CLK(CLK), .RST_N(RST_N), .HALL(HALL), .DUTY(DUTY), .EN(EN), .DIR(DIR),
        .BRAKE(BRAKE), .CLR_FAULT(CLR_FAULT), .A(A), .B(B), .C(C), .AA(AA), .BB(BB),
        .CC(CC), .FAULT(FAULT), .STALL(STALL), .COMM_PERIOD(COMM_PERIOD)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) if ((A && AA) || (B && BB) || (C && CC)) ovl++;

    function automatic logic [5:0] gates();
        return {A, B, C, AA, BB, CC};
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic win(input int n, output int na, output int nbb);
        na = 0; nbb = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            na  += int'(A);
            nbb += int'(BB);
        end
    endtask

    initial begin
        int na, nbb, n, i, bb_off, cc_on;
        logic found, prev;
        logic [5:0] g0;
        int chg;

        tab[0]  = '{3'b100, 1'b0, 6'b100_001, 16'd0};
        tab[1]  = '{3'b110, 1'b0, 6'b010_001, 16'd1000};
        tab[2]  = '{3'b010, 1'b0, 6'b010_100, 16'd1000};
        tab[3]  = '{3'b011, 1'b0, 6'b001_100, 16'd1000};
        tab[4]  = '{3'b001, 1'b0, 6'b001_010, 16'd1000};
        tab[5]  = '{3'b101, 1'b0, 6'b100_010, 16'd1000};
        tab[6]  = '{3'b100, 1'b1, 6'b001_100, 16'd1000};
        tab[7]  = '{3'b110, 1'b1, 6'b001_010, 16'd1000};
        tab[8]  = '{3'b010, 1'b1, 6'b100_010, 16'd1000};
        tab[9]  = '{3'b011, 1'b1, 6'b100_001, 16'd1000};
        tab[10] = '{3'b001, 1'b1, 6'b010_001, 16'd1000};
        tab[11] = '{3'b101, 1'b1, 6'b010_100, 16'd1000};

        // Reset with drive requested
        RST_N = 1'b0; EN = 1'b1; DUTY = 4'd6; HALL = 3'b101;
        DIR = 1'b0; BRAKE = 1'b0; CLR_FAULT = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_gates", int'(gates()), 0);
        chk("rst_fault", int'(FAULT), 0);
        chk("rst_stall", int'(STALL), 0);
        chk("rst_period", int'(COMM_PERIOD), 0);
        RST_N = 1'b1;
        repeat (6 + DT) @(negedge CLK);
        chk("lat_bb_early", int'(BB), 0);
        @(negedge CLK);
        chk("lat_bb_on", int'(BB), 1);
        chk("first_period", int'(COMM_PERIOD), 7);
        repeat (40) @(negedge CLK);
        win(15, na, nbb);
        chk("chop_a_6of15", na, 6);
        chk("chop_bb_steady", nbb, 15);

        // Commutation table, full duty so high side reads as a steady level
        DUTY = 4'd15;
        for (int k = 0; k < 12; k++) begin
            HALL = tab[k].hall;
            DIR  = tab[k].dir;
            repeat (1000) @(negedge CLK);
            chk($sformatf("tab%0d_gates", k), int'(gates()), int'(tab[k].gates));
            if (tab[k].per != 16'd0)
                chk($sformatf("tab%0d_period", k), int'(COMM_PERIOD), int'(tab[k].per));
        end
        chk("no_stall", int'(STALL), 0);

        // Two-cycle Hall glitch must be filtered
        g0 = gates(); chg = 0;
        HALL = 3'b100;
        repeat (2) @(negedge CLK);
        HALL = 3'b101;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (gates() != g0) chg++;
        end
        chk("glitch_nochange", chg, 0);
        chk("glitch_gates", int'(gates()), int'(6'b010_100));
        chk("glitch_period", int'(COMM_PERIOD), 1000);

        // Invalid Hall code, sticky fault, clear rules
        HALL = 3'b111;
        repeat (10) @(negedge CLK);
        chk("fault_set", int'(FAULT), 1);
        chk("fault_gates", int'(gates()), 0);
        CLR_FAULT = 1'b1; @(negedge CLK); CLR_FAULT = 1'b0;
        repeat (3) @(negedge CLK);
        chk("fault_clr_ignored", int'(FAULT), 1);
        HALL = 3'b101;
        repeat (10) @(negedge CLK);
        chk("fault_sticky", int'(FAULT), 1);
        chk("fault_sticky_gates", int'(gates()), 0);
        CLR_FAULT = 1'b1; @(negedge CLK); CLR_FAULT = 1'b0;
        chk("fault_cleared", int'(FAULT), 0);
        repeat (4 + DT) @(negedge CLK);
        chk("fault_resume", int'(gates()), int'(6'b010_100));

        // Brake and disable
        BRAKE = 1'b1;
        repeat (3 + DT) @(negedge CLK);
        chk("brake_gates", int'(gates()), int'(6'b000_111));
        BRAKE = 1'b0;
        repeat (4 + DT) @(negedge CLK);
        chk("brake_release", int'(gates()), int'(6'b010_100));
        EN = 1'b0;
        repeat (3 + DT) @(negedge CLK);
        chk("idle_gates", int'(gates()), 0);
        EN = 1'b1;
        DIR = 1'b0;
        DUTY = 4'd6;
        repeat (40) @(negedge CLK);

        // Duty change mid-period takes effect only after the wrap
        found = 1'b0; prev = A; i = 0;
        while (!found && i < 40) begin
            @(negedge CLK);
            found = !prev && A;
            prev  = A;
            i++;
        end
        chk("duty_sync", int'(found), 1);
        repeat (3) @(negedge CLK);
        DUTY = 4'd12;
        n = int'(A);
        for (int k = 0; k < 11; k++) begin
            @(negedge CLK);
            n += int'(A);
        end
        chk("duty_old_rest", n, 3);
        win(15, na, nbb);
        chk("duty_new_12", na, 12);
        DUTY = 4'd15;
        repeat (40) @(negedge CLK);
        win(15, na, nbb);
        chk("duty_full", na, 15);
        DUTY = 4'd0;
        repeat (40) @(negedge CLK);
        win(15, na, nbb);
        chk("duty_zero", na, 0);

        // Role hand-over on 101->100: B low releases, C low follows after dead time
        DUTY = 4'd15;
        repeat (40) @(negedge CLK);
        HALL = 3'b100;
        bb_off = 0; cc_on = 0; na = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge CLK);
            if (bb_off == 0 && !BB) bb_off = k;
            if (cc_on == 0 && CC) cc_on = k;
            na += int'(A);
        end
        chk("ho_bb_off", bb_off, 7);
        chk("ho_dead_gap", cc_on - bb_off, DT);
        chk("ho_a_held", na, 20);

        chk("no_overlap", ovl, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
